// File: rtl/rf_ctx_ctrl_pkg.sv
// Shared constants for the register-file context controller: RF write codes,
// sequencer state encoding and the default context-area base address.
package rf_ctx_ctrl_pkg;

  localparam logic [1:0] RF_WRITE_NONE = 2'b00;
  localparam logic [1:0] RF_WRITE_LOW  = 2'b01;
  localparam logic [1:0] RF_WRITE_HIGH = 2'b10;
  localparam logic [1:0] RF_WRITE_FULL = 2'b11;

  localparam logic [15:0] CTX_BASE_DEFAULT = 16'hFF00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } ctx_state_e;

  // Context slot address; wraps at 16 bits
  function automatic logic [15:0] ctx_addr(input logic [15:0] base, input logic [2:0] idx);
    return base + {13'b0, idx};
  endfunction

endpackage

// File: rtl/rf_ctx_ctrl_if.sv
// Req/ack memory port between the context controller and the data-memory arbiter.
interface rf_ctx_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/rf_ctx_ctrl.sv
// Interrupt context save/restore sequencer and RF port arbiter.
// state   | meaning
// IDLE    | core owns the RF ports, waiting for save_req/restore_req
// SAVE    | copying r[idx] to CTX_BASE+idx, core stalled
// RESTORE | copying CTX_BASE+idx into r[idx], core stalled
// DONE    | one-cycle ctx_done pulse before handing the RF back
module rf_ctx_ctrl
  import rf_ctx_ctrl_pkg::*;
#(
  parameter int          NREGS    = 8,
  parameter logic [15:0] CTX_BASE = CTX_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           core_addr_a,
  input  logic [2:0]           core_addr_b,
  input  logic [15:0]          core_din,
  input  logic [1:0]           core_write,
  output logic                 core_stall,
  input  logic                 save_req,
  input  logic                 restore_req,
  output logic                 ctx_done,
  output logic [2:0]           rf_addr_a,
  output logic [2:0]           rf_addr_b,
  output logic [15:0]          rf_din,
  output logic [1:0]           rf_write,
  input  logic [15:0]          rf_dout_a,
  rf_ctx_ctrl_if.master        mem
);

  localparam logic [2:0] LAST_IDX = 3'(NREGS - 1);

  ctx_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    core_stall    = 1'b1;
    ctx_done      = 1'b0;
    rf_addr_a     = core_addr_a;
    rf_addr_b     = core_addr_b;
    rf_din        = core_din;
    rf_write      = core_write;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = ctx_addr(CTX_BASE, idx_q);
    mem.mem_wdata = 16'h0000;

    unique case (state_q)
      IDLE: begin
        core_stall = 1'b0;
        idx_d      = 3'd0;
        if (save_req)         state_d = SAVE;
        else if (restore_req) state_d = RESTORE;
      end
      SAVE: begin
        rf_addr_a     = idx_q;
        rf_write      = RF_WRITE_NONE;
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_wdata = rf_dout_a;
        if (mem.mem_ack) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      RESTORE: begin
        rf_addr_a   = idx_q;
        rf_write    = RF_WRITE_NONE;
        mem.mem_req = 1'b1;
        // RF is only written in the cycle the read data is valid
        if (mem.mem_ack) begin
          rf_din   = mem.mem_rdata;
          rf_write = RF_WRITE_FULL;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      DONE: begin
        ctx_done = 1'b1;
        rf_write = RF_WRITE_NONE;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rf_ctx_ctrl.sv
// Bench for rf_ctx_ctrl: RF and wait-state memory models, scoreboards on memory
// writes and sequencer-driven RF writes, one task per scenario.
module tb_rf_ctx_ctrl;
  import rf_ctx_ctrl_pkg::*;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  core_addr_a, core_addr_b;
  logic [15:0] core_din;
  logic [1:0]  core_write;
  logic        core_stall;
  logic        save_req, restore_req;
  logic        ctx_done;
  logic [2:0]  rf_addr_a, rf_addr_b;
  logic [15:0] rf_din;
  logic [1:0]  rf_write;
  logic [15:0] rf_dout_a;

  rf_ctx_ctrl_if mif ();

  rf_ctx_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_addr_a (core_addr_a),
    .core_addr_b (core_addr_b),
    .core_din    (core_din),
    .core_write  (core_write),
    .core_stall  (core_stall),
    .save_req    (save_req),
    .restore_req (restore_req),
    .ctx_done    (ctx_done),
    .rf_addr_a   (rf_addr_a),
    .rf_addr_b   (rf_addr_b),
    .rf_din      (rf_din),
    .rf_write    (rf_write),
    .rf_dout_a   (rf_dout_a),
    .mem         (mif.master)
  );

  int n_vec = 0;
  int n_err = 0;

  exp_t mem_q[$];
  exp_t rf_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file model
  logic [15:0] rf_model [0:7];
  assign rf_dout_a = rf_model[rf_addr_a];
  always @(posedge clk) begin
    case (rf_write)
      RF_WRITE_FULL: rf_model[rf_addr_a] <= rf_din;
      RF_WRITE_HIGH: rf_model[rf_addr_a][15:8] <= rf_din[15:8];
      RF_WRITE_LOW:  rf_model[rf_addr_a][7:0]  <= rf_din[7:0];
      default: ;
    endcase
  end

  // memory model with programmable wait states
  logic [15:0] mem_model [0:255];
  int          mem_waits = 0;
  int          wait_cnt  = 0;
  logic        preload   = 1'b0;
  assign mif.mem_ack   = mif.mem_req && (wait_cnt == mem_waits);
  assign mif.mem_rdata = mem_model[mif.mem_addr[7:0]];
  always @(posedge clk) begin
    if (!mif.mem_req || mif.mem_ack) wait_cnt <= 0;
    else                             wait_cnt <= wait_cnt + 1;
    if (preload) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= 16'hA0A0 ^ 16'(i);
    end else if (mif.mem_req && mif.mem_ack && mif.mem_we) begin
      mem_model[mif.mem_addr[7:0]] <= mif.mem_wdata;
    end
  end

  // monitors: scoreboards, address stability, write-only-on-ack
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  always @(negedge clk) begin
    exp_t e;
    if (mif.mem_req && mif.mem_ack && mif.mem_we) begin
      n_vec++;
      if (mem_q.size() == 0) begin
        n_err++;
        $display("FAIL mem_write_unexpected: addr=%h data=%h, none expected", mif.mem_addr, mif.mem_wdata);
      end else begin
        e = mem_q.pop_front();
        if (mif.mem_addr !== e.a || mif.mem_wdata !== e.d) begin
          n_err++;
          $display("FAIL mem_write: got addr=%h data=%h, want addr=%h data=%h",
                   mif.mem_addr, mif.mem_wdata, e.a, e.d);
        end
      end
    end
    if (core_stall && rf_write !== RF_WRITE_NONE) begin
      n_vec++;
      if (rf_q.size() == 0) begin
        n_err++;
        $display("FAIL rf_write_unexpected: addr=%0d data=%h code=%b", rf_addr_a, rf_din, rf_write);
      end else begin
        e = rf_q.pop_front();
        if ({13'b0, rf_addr_a} !== e.a || rf_din !== e.d || rf_write !== RF_WRITE_FULL) begin
          n_err++;
          $display("FAIL rf_restore_write: got r%0d=%h code=%b, want r%0d=%h code=%b",
                   rf_addr_a, rf_din, rf_write, e.a, e.d, RF_WRITE_FULL);
        end
      end
    end
    if (mif.mem_req && !mif.mem_we) begin
      n_vec++;
      if ((rf_write === RF_WRITE_FULL) !== mif.mem_ack) begin
        n_err++;
        $display("FAIL restore_write_on_ack: rf_write=%b ack=%b, want FULL exactly when ack",
                 rf_write, mif.mem_ack);
      end
    end
    if (prev_wait && mif.mem_req) begin
      n_vec++;
      if (mif.mem_addr !== prev_addr) begin
        n_err++;
        $display("FAIL addr_stable: got %h, want %h", mif.mem_addr, prev_addr);
      end
    end
    prev_wait = mif.mem_req && !mif.mem_ack;
    prev_addr = mif.mem_addr;
  end

  task automatic core_wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    core_addr_a = a;
    core_din    = d;
    core_write  = RF_WRITE_FULL;
    @(posedge clk);
    #1 core_write = RF_WRITE_NONE;
  endtask

  task automatic run_seq(input logic do_save, input logic do_restore, input int pulse_c,
                         input int rst_c, output int stall_n, output int done_n,
                         output int done_at, output logic we_first);
    logic finished = 1'b0;
    stall_n = 0; done_n = 0; done_at = 0; we_first = 1'b0;
    @(negedge clk);
    save_req    = do_save;
    restore_req = do_restore;
    @(posedge clk);
    #1 save_req = 1'b0;
    restore_req = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) we_first = mif.mem_we;
      if (core_stall) stall_n++;
      if (ctx_done) begin done_n++; done_at = c; end
      if (!core_stall) begin
        finished = 1'b1;
        break;
      end
      restore_req = (c == pulse_c);
      if (c == rst_c) rst_n = 1'b0;
    end
    restore_req = 1'b0;
    n_vec++;
    if (!finished) begin
      n_err++;
      $display("FAIL seq_timeout: core_stall still %b after 200 cycles, want 0", core_stall);
    end
  endtask

  task automatic check_seq(input string nm, input int stall_n, input int done_n, input int done_at,
                           input int exp_stall, input int exp_done_n, input int exp_done_at);
    n_vec++;
    if (stall_n !== exp_stall) begin
      n_err++;
      $display("FAIL %s_stall_len: got %0d, want %0d", nm, stall_n, exp_stall);
    end
    n_vec++;
    if (done_n !== exp_done_n || done_at !== exp_done_at) begin
      n_err++;
      $display("FAIL %s_ctx_done: got %0d pulses at cycle %0d, want %0d at %0d",
               nm, done_n, done_at, exp_done_n, exp_done_at);
    end
    n_vec++;
    if (mem_q.size() != 0 || rf_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_scoreboard_left: mem=%0d rf=%0d, want 0 0", nm, mem_q.size(), rf_q.size());
    end
  endtask

  task automatic push_save;
    for (int i = 0; i < 8; i++) mem_q.push_back('{16'hFF00 + 16'(i), rf_model[i]});
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    core_addr_a = 3'd5; core_addr_b = 3'd6; core_din = 16'hBEEF; core_write = RF_WRITE_NONE;
    save_req = 1'b0; restore_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({core_stall, ctx_done, mif.mem_req, mif.mem_we} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: stall/done/req/we=%b, want 0000",
               {core_stall, ctx_done, mif.mem_req, mif.mem_we});
    end
    n_vec++;
    if (mif.mem_addr !== 16'hFF00 || mif.mem_wdata !== 16'h0) begin
      n_err++;
      $display("FAIL reset_mem: addr=%h wdata=%h, want FF00 0000", mif.mem_addr, mif.mem_wdata);
    end
    n_vec++;
    if (rf_addr_a !== 3'd5 || rf_addr_b !== 3'd6 || rf_din !== 16'hBEEF || rf_write !== RF_WRITE_NONE) begin
      n_err++;
      $display("FAIL reset_rf_mirror: a=%0d b=%0d din=%h w=%b, want 5 6 BEEF %b",
               rf_addr_a, rf_addr_b, rf_din, rf_write, RF_WRITE_NONE);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    core_addr_a = 3'd3; core_addr_b = 3'd1; core_din = 16'h1234; core_write = RF_WRITE_FULL;
    #1;
    n_vec++;
    if (rf_addr_a !== 3'd3 || rf_addr_b !== 3'd1 || rf_din !== 16'h1234 || rf_write !== RF_WRITE_FULL
        || core_stall !== 1'b0 || mif.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL passthrough: a=%0d b=%0d din=%h w=%b stall=%b req=%b, want 3 1 1234 %b 0 0",
               rf_addr_a, rf_addr_b, rf_din, rf_write, core_stall, mif.mem_req, RF_WRITE_FULL);
    end
    @(posedge clk);
    #1 core_write = RF_WRITE_NONE;
    n_vec++;
    if (rf_model[3] !== 16'h1234) begin
      n_err++;
      $display("FAIL passthrough_rf: r3=%h, want 1234", rf_model[3]);
    end
  endtask

  task automatic test_save;
    int s, d, at; logic we;
    for (int i = 0; i < 8; i++) core_wr(3'(i), 16'h1000 + 16'(i));
    mem_waits = 0;
    push_save();
    run_seq(1'b1, 1'b0, 0, 0, s, d, at, we);
    check_seq("save", s, d, at, 9, 1, 9);
  endtask

  task automatic test_restore;
    int s, d, at; logic we;
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
    mem_waits = 2;
    for (int i = 0; i < 8; i++) rf_q.push_back('{16'(i), 16'hA0A0 ^ 16'(i)});
    run_seq(1'b0, 1'b1, 0, 0, s, d, at, we);
    check_seq("restore", s, d, at, 25, 1, 25);
    n_vec++;
    if (rf_model[5] !== 16'hA0A5) begin
      n_err++;
      $display("FAIL restore_r5: got %h, want A0A5", rf_model[5]);
    end
  endtask

  task automatic test_both_req;
    int s, d, at; logic we;
    mem_waits = 0;
    push_save();
    run_seq(1'b1, 1'b1, 3, 0, s, d, at, we);
    n_vec++;
    if (we !== 1'b1) begin
      n_err++;
      $display("FAIL both_req_we: mem_we=%b, want 1", we);
    end
    check_seq("both_req", s, d, at, 9, 1, 9);
  endtask

  task automatic test_reset_mid;
    int s, d, at; logic we;
    mem_waits = 0;
    for (int i = 0; i < 3; i++) mem_q.push_back('{16'hFF00 + 16'(i), rf_model[i]});
    run_seq(1'b1, 1'b0, 0, 3, s, d, at, we);
    n_vec++;
    if (mif.mem_req !== 1'b0 || core_stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_idle: req=%b stall=%b, want 0 0", mif.mem_req, core_stall);
    end
    check_seq("reset_mid", s, d, at, 3, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_save();
    run_seq(1'b1, 1'b0, 0, 0, s, d, at, we);
    check_seq("restart", s, d, at, 9, 1, 9);
  endtask

  task automatic test_back_to_back;
    int s, d, at; logic we;
    for (int i = 0; i < 8; i++) core_wr(3'(i), 16'h5A00 + 16'(i));
    mem_waits = 0;
    push_save();
    run_seq(1'b1, 1'b0, 0, 0, s, d, at, we);
    check_seq("b2b_save", s, d, at, 9, 1, 9);
    for (int i = 0; i < 8; i++) core_wr(3'(i), 16'hFFFF - 16'(i));
    n_vec++;
    if (rf_model[2] !== 16'hFFFD) begin
      n_err++;
      $display("FAIL b2b_overwrite: r2=%h, want FFFD", rf_model[2]);
    end
    mem_waits = 1;
    for (int i = 0; i < 8; i++) rf_q.push_back('{16'(i), 16'h5A00 + 16'(i)});
    run_seq(1'b0, 1'b1, 0, 0, s, d, at, we);
    check_seq("b2b_restore", s, d, at, 17, 1, 17);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (rf_model[i] !== 16'h5A00 + 16'(i)) begin
        n_err++;
        $display("FAIL b2b_rf r%0d: got %h, want %h", i, rf_model[i], 16'h5A00 + 16'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_save();
    test_restore();
    test_both_req();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_ctx_ctrl.md
Name: rf_ctx_ctrl

Overview:
- Interrupt context save/restore sequencer and port arbiter for the 8x16 register file.
- In IDLE, core register-file requests pass straight through to the RF.
- On a save or restore request, it takes the RF ports and the core stalls. It then walks r0..r(NREGS-1), moving each register over a req/ack memory port to or from a fixed context area.
- It sits between the core decode/writeback stage, the RF and the data-memory arbiter.

Parameters:
- NREGS, 8, registers to save/restore (1..8); register index width is 3.
- CTX_BASE, 16'hFF00, memory word address of the slot for r0; rN is at CTX_BASE+N.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- core_addr_a  in  3  core RF port A address (also the write address)
- core_addr_b  in  3  core RF port B address
- core_din  in  16  core RF write data
- core_write  in  2  core RF write code (RF_WRITE_* constants)
- core_stall  out  1  core must hold; its RF requests are ignored
- save_req  in  1  one-cycle pulse: start context save
- restore_req  in  1  one-cycle pulse: start context restore
- ctx_done  out  1  one-cycle pulse: sequence complete
- rf_addr_a  out  3  to RF addr_a
- rf_addr_b  out  3  to RF addr_b
- rf_din  out  16  to RF din
- rf_write  out  2  to RF write
- rf_dout_a  in  16  from RF dout_a (combinational read)
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write (save), 0 = read (restore)
- mem_addr  out  16  memory word address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle acknowledge; may arrive in the same cycle as mem_req

Behaviour:
- Clock and reset: rst_n is synchronous, active-low; clock clk.
- States: IDLE, SAVE, RESTORE, DONE. Index counter idx is 3 bits.
- Reset values:
  - state = IDLE, idx = 0.
  - core_stall = 0, ctx_done = 0, mem_req = 0, mem_we = 0.
  - mem_addr = CTX_BASE, mem_wdata = 0.
  - rf_* outputs mirror the core_* inputs.
- IDLE:
  - rf_addr_a/b, rf_din and rf_write equal core_addr_a/b, core_din and core_write combinationally.
  - save_req -> SAVE; else restore_req -> RESTORE. Save wins if both pulse together; idx = 0.
  - The core access in the accept cycle still completes.
- SAVE:
  - rf_addr_a = idx, rf_write = RF_WRITE_NONE.
  - mem_req = 1, mem_we = 1, mem_addr = CTX_BASE+idx, mem_wdata = rf_dout_a.
  - On mem_ack: if idx == NREGS-1 -> DONE, else idx+1 and the next request is presented the following cycle. mem_req stays high across back-to-back transfers.
- RESTORE:
  - mem_req = 1, mem_we = 0, mem_addr = CTX_BASE+idx.
  - In the mem_ack cycle only: rf_addr_a = idx, rf_din = mem_rdata, rf_write = RF_WRITE_FULL. Otherwise rf_write = RF_WRITE_NONE.
  - idx advances and terminates as in SAVE.
- DONE: ctx_done = 1, mem_req = 0, rf_write = RF_WRITE_NONE for one cycle, then IDLE.
- core_stall = 1 in SAVE, RESTORE and DONE; 0 in IDLE.
- While not IDLE, rf_addr_b = core_addr_b; port B read is harmless.
- save_req/restore_req outside IDLE are ignored; no queuing.
- Latency with zero-wait memory: accept cycle + NREGS transfer cycles + 1 DONE cycle. core_stall is high for NREGS+1 cycles.
- mem_addr is 16-bit wrap-around arithmetic.
- Reset mid-sequence: immediate return to IDLE, mem_req drops the same edge, no ctx_done. A partially restored RF is left as is.
- mem_ack while mem_req = 0 is ignored.

Decomposition:
- Shared constants file:
  - RF_WRITE_NONE/FULL/HIGH/LOW encodings, already shared with the RF.
  - New ctx_state enum (IDLE/SAVE/RESTORE/DONE).
  - CTX_BASE default value.
- No sub-module; the output mux and the FSM both live in rf_ctx_ctrl.

Test Plan:
- Reset, then IDLE pass-through: core_addr_a = 3, core_din = 16'h1234, core_write = FULL -> RF r3 = 16'h1234; core_stall = 0; mem_req = 0.
- Save with zero-wait ack (r0..r7 = 16'h1000+N) -> memory writes 16'h1000..16'h1007 at FF00..FF07 on consecutive cycles; ctx_done pulse on cycle 9 after accept; core_stall high for 9 cycles.
- Restore with 2-wait-state ack (memory FF00+N = 16'hA0A0^N) -> mem_addr held stable through the waits; rf_write = FULL only in ack cycles; final r5 = 16'hA0A5.
- save_req and restore_req in the same cycle -> SAVE performed, mem_we = 1. restore_req pulsed mid-save -> ignored; exactly one ctx_done.
- rst_n low after the 3rd save ack -> next cycle IDLE, mem_req = 0, core_stall = 0, ctx_done never pulses; a new save restarts at FF00.
- Back-to-back save then restore: RF written with core values, save, then RF overwritten by the core, then restore -> RF equals the saved values.
